// File: rtl/rob_queue.sv
// rob_queue: circular reorder buffer with WAYS-wide dispatch, completion and
// in-order retire, plus a single-cycle branch-recovery flush.
//
// Ports (way i occupies bits [i*W +: W] of each flattened bus):
//   clock_i, reset_i           clock, synchronous active-high reset
//   dispatch_valid_i [WAYS]    dispatch request per way (contiguous prefix)
//   dispatch_in_i    [WAYS]    ROB packets to enqueue
//   dispatch_idx_o   [WAYS]    entry index offered to each dispatch way
//   free_slots_o               ROB_SZ minus registered entry count
//   cmpl_*_i         [WAYS]    completion writeback (valid/idx/value/precise/target)
//   retire_rob_out_o [WAYS]    oldest WAYS entries, head first, zero if absent
//   retire_ack_i     [WAYS]    retire-stage accept flags (leading-ones count)
//   br_recover_enable_i        flush everything
//
// ROB packet layout (PKT_W = 116 bits, LSB first):
//   [31:0] target_pc, [32] precise_state_enable, [64:33] dest_value,
//   [65] complete, [66] halt, [98:67] npc, [103:99] ar_idx,
//   [109:104] told_idx, [115:110] t_idx
module rob_queue #(
    parameter int unsigned ROB_SZ = 32,
    parameter int unsigned WAYS   = 3,
    localparam int unsigned IDX_W  = $clog2(ROB_SZ),
    localparam int unsigned CNT_W  = $clog2(ROB_SZ + 1),
    localparam int unsigned DATA_W = 32,
    localparam int unsigned PKT_W  = 116
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [WAYS-1:0]         dispatch_valid_i,
    input  logic [WAYS*PKT_W-1:0]   dispatch_in_i,
    output logic [WAYS*IDX_W-1:0]   dispatch_idx_o,
    output logic [CNT_W-1:0]        free_slots_o,
    input  logic [WAYS-1:0]         cmpl_valid_i,
    input  logic [WAYS*IDX_W-1:0]   cmpl_idx_i,
    input  logic [WAYS*DATA_W-1:0]  cmpl_value_i,
    input  logic [WAYS-1:0]         cmpl_precise_i,
    input  logic [WAYS*DATA_W-1:0]  cmpl_target_pc_i,
    output logic [WAYS*PKT_W-1:0]   retire_rob_out_o,
    input  logic [WAYS-1:0]         retire_ack_i,
    input  logic                    br_recover_enable_i
);

    localparam int unsigned TPC_LSB  = 0;
    localparam int unsigned PREC_BIT = 32;
    localparam int unsigned DVAL_LSB = 33;
    localparam int unsigned CMPL_BIT = 65;

    logic [PKT_W-1:0]  rob_q [ROB_SZ];
    logic [PKT_W-1:0]  rob_d [ROB_SZ];
    logic [ROB_SZ-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  ret_cnt, disp_cnt;

    // Retire window, dispatch offers and the accepted/retired counts
    always_comb begin
        logic [IDX_W-1:0] ridx;
        logic             ret_go, disp_go, way_ok;
        retire_rob_out_o = '0;
        dispatch_idx_o   = '0;
        free_slots_o     = CNT_W'(ROB_SZ) - count_q;
        ret_cnt          = '0;
        disp_cnt         = '0;
        ret_go           = 1'b1;
        disp_go          = 1'b1;
        for (int unsigned i = 0; i < WAYS; i++) begin
            ridx   = head_q + IDX_W'(i);
            way_ok = 1'b0;
            if (CNT_W'(i) < count_q) begin
                retire_rob_out_o[i*PKT_W +: PKT_W] = rob_q[ridx];
                way_ok = valid_q[ridx] & rob_q[ridx][CMPL_BIT];
            end
            // Retire stops at the first unacked or not-yet-complete way
            if (ret_go && retire_ack_i[i] && way_ok) begin
                ret_cnt = ret_cnt + CNT_W'(1);
            end else begin
                ret_go = 1'b0;
            end
            dispatch_idx_o[i*IDX_W +: IDX_W] = tail_q + IDX_W'(i);
            // Space is judged on the registered count only
            if (disp_go && dispatch_valid_i[i] && (CNT_W'(i) < free_slots_o)) begin
                disp_cnt = disp_cnt + CNT_W'(1);
            end else begin
                disp_go = 1'b0;
            end
        end
    end

    // Next state: completions, then retire invalidation, then dispatch writes
    always_comb begin
        logic [IDX_W-1:0] widx;
        logic [PKT_W-1:0] pkt;
        rob_d   = rob_q;
        valid_d = valid_q;
        head_d  = head_q + IDX_W'(ret_cnt);
        tail_d  = tail_q + IDX_W'(disp_cnt);
        count_d = count_q - ret_cnt + disp_cnt;
        widx    = '0;
        pkt     = '0;
        // Ascending way order lets the higher way win on an index collision
        for (int unsigned i = 0; i < WAYS; i++) begin
            widx = cmpl_idx_i[i*IDX_W +: IDX_W];
            if (cmpl_valid_i[i] && valid_q[widx]) begin
                pkt = rob_d[widx];
                pkt[CMPL_BIT]               = 1'b1;
                pkt[DVAL_LSB +: DATA_W]     = cmpl_value_i[i*DATA_W +: DATA_W];
                pkt[PREC_BIT]               = cmpl_precise_i[i];
                pkt[TPC_LSB +: DATA_W]      = cmpl_target_pc_i[i*DATA_W +: DATA_W];
                rob_d[widx] = pkt;
            end
        end
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (CNT_W'(i) < ret_cnt) begin
                valid_d[head_q + IDX_W'(i)] = 1'b0;
            end
        end
        // Dispatch only lands in free slots, so it never collides with the above
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (CNT_W'(i) < disp_cnt) begin
                widx = tail_q + IDX_W'(i);
                pkt  = dispatch_in_i[i*PKT_W +: PKT_W];
                pkt[CMPL_BIT:0] = '0;
                rob_d[widx]   = pkt;
                valid_d[widx] = 1'b1;
            end
        end
        if (br_recover_enable_i) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // State registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int unsigned e = 0; e < ROB_SZ; e++) begin
                rob_q[e] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            rob_q   <= rob_d;
        end
    end

endmodule

// File: tb/tb_rob_queue.sv
// Directed bench for rob_queue: dispatch, completion, retire, full/wrap,
// flush and reset behaviour against hand-computed values.
module tb_rob_queue;

    localparam int WAYS  = 3;
    localparam int IDX_W = 5;
    localparam int PKT_W = 116;

    logic                  clock;
    logic                  reset;
    logic [WAYS-1:0]       dispatch_valid;
    logic [WAYS*PKT_W-1:0] dispatch_in;
    logic [WAYS*IDX_W-1:0] dispatch_idx;
    logic [5:0]            free_slots;
    logic [WAYS-1:0]       cmpl_valid;
    logic [WAYS*IDX_W-1:0] cmpl_idx;
    logic [WAYS*32-1:0]    cmpl_value;
    logic [WAYS-1:0]       cmpl_precise;
    logic [WAYS*32-1:0]    cmpl_target_pc;
    logic [WAYS*PKT_W-1:0] retire_rob_out;
    logic [WAYS-1:0]       retire_ack;
    logic                  br_recover;

    int n_vec = 0;
    int n_err = 0;

    rob_queue dut (
        .clock_i             (clock),
        .reset_i             (reset),
        .dispatch_valid_i    (dispatch_valid),
        .dispatch_in_i       (dispatch_in),
        .dispatch_idx_o      (dispatch_idx),
        .free_slots_o        (free_slots),
        .cmpl_valid_i        (cmpl_valid),
        .cmpl_idx_i          (cmpl_idx),
        .cmpl_value_i        (cmpl_value),
        .cmpl_precise_i      (cmpl_precise),
        .cmpl_target_pc_i    (cmpl_target_pc),
        .retire_rob_out_o    (retire_rob_out),
        .retire_ack_i        (retire_ack),
        .br_recover_enable_i (br_recover)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Dispatch payload with junk in the fields the ROB must clear
    function automatic logic [PKT_W-1:0] mkpkt(input logic [31:0] npc);
        logic [PKT_W-1:0] p;
        p = '0;
        p[115:110] = npc[7:2];
        p[109:104] = npc[8:3];
        p[103:99]  = npc[8:4];
        p[98:67]   = npc;
        p[66]      = npc[2];
        p[65]      = 1'b1;
        p[64:33]   = 32'hDEADBEEF;
        p[32]      = 1'b1;
        p[31:0]    = 32'hFFFF0000;
        return p;
    endfunction

    function automatic logic [PKT_W-1:0] exp_disp(input logic [31:0] npc);
        logic [PKT_W-1:0] p;
        p = mkpkt(npc);
        p[65:0] = '0;
        return p;
    endfunction

    function automatic logic [PKT_W-1:0] rob_out(input int w);
        return retire_rob_out[w*PKT_W +: PKT_W];
    endfunction

    function automatic logic [14:0] idx3(input int a, input int b, input int c);
        return {5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        dispatch_valid = '0;
        dispatch_in    = '0;
        cmpl_valid     = '0;
        cmpl_idx       = '0;
        cmpl_value     = '0;
        cmpl_precise   = '0;
        cmpl_target_pc = '0;
        retire_ack     = '0;
        br_recover     = 1'b0;
    endtask

    task automatic set_disp(input int w, input logic [31:0] npc);
        dispatch_valid[w] = 1'b1;
        dispatch_in[w*PKT_W +: PKT_W] = mkpkt(npc);
    endtask

    task automatic set_cmpl(input int w, input int idx, input logic [31:0] val,
                            input logic prec, input logic [31:0] tpc);
        cmpl_valid[w] = 1'b1;
        cmpl_idx[w*IDX_W +: IDX_W] = 5'(idx);
        cmpl_value[w*32 +: 32] = val;
        cmpl_precise[w] = prec;
        cmpl_target_pc[w*32 +: 32] = tpc;
    endtask

    task automatic flush();
        idle();
        br_recover = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        logic [PKT_W-1:0] p;
        idle();
        reset = 1'b1;
        tick();
        chk("rst_free", 128'(free_slots), 128'(32));
        chk("rst_didx", 128'(dispatch_idx), 128'(idx3(0, 1, 2)));
        chk("rst_out", 128'(|retire_rob_out), 128'(0));
        reset = 1'b0;
        tick();
        chk("post_rst_free", 128'(free_slots), 128'(32));
        chk("post_rst_didx", 128'(dispatch_idx), 128'(idx3(0, 1, 2)));

        // Basic dispatch of three ways
        set_disp(0, 32'h100); set_disp(1, 32'h104); set_disp(2, 32'h108);
        tick(); idle();
        chk("disp_free", 128'(free_slots), 128'(29));
        chk("disp_out0", 128'(rob_out(0)), 128'(exp_disp(32'h100)));
        chk("disp_out2", 128'(rob_out(2)), 128'(exp_disp(32'h108)));
        chk("disp_didx", 128'(dispatch_idx), 128'(idx3(3, 4, 5)));

        // Completion is not visible combinationally, only a cycle later
        set_cmpl(0, 1, 32'hAAAA, 1'b0, 32'h0);
        #1;
        p = rob_out(1);
        chk("cmpl_not_comb", 128'(p[65]), 128'(0));
        tick(); idle();
        p = rob_out(1);
        chk("cmpl1_done", 128'(p[65]), 128'(1));
        chk("cmpl1_val", 128'(p[64:33]), 128'(32'hAAAA));
        // Head not complete: all-ones ack retires nothing
        retire_ack = 3'b111;
        tick(); idle();
        chk("ret_blocked", 128'(free_slots), 128'(29));
        set_cmpl(0, 0, 32'h5555, 1'b0, 32'h0);
        tick(); idle();
        retire_ack = 3'b011;
        tick(); idle();
        chk("ret2_free", 128'(free_slots), 128'(31));
        chk("ret2_out0", 128'(rob_out(0)), 128'(exp_disp(32'h108)));
        chk("ret2_out1", 128'(rob_out(1)), 128'(0));

        // Flush overrides dispatch, completion and retire
        set_disp(0, 32'h200); set_disp(1, 32'h204); set_disp(2, 32'h208);
        set_cmpl(0, 2, 32'h1, 1'b0, 32'h0);
        retire_ack = 3'b111;
        br_recover = 1'b1;
        tick(); idle();
        chk("flush_free", 128'(free_slots), 128'(32));
        chk("flush_didx", 128'(dispatch_idx), 128'(idx3(0, 1, 2)));
        chk("flush_out", 128'(|retire_rob_out), 128'(0));

        // Fill to 32; the final group of three only partly fits
        for (int c = 0; c < 10; c++) begin
            for (int w = 0; w < 3; w++) set_disp(w, 32'h1000 + 32'(4 * (3 * c + w)));
            tick(); idle();
        end
        chk("fill30_free", 128'(free_slots), 128'(2));
        for (int w = 0; w < 3; w++) set_disp(w, 32'h1078 + 32'(4 * w));
        chk("fill_didx", 128'(dispatch_idx), 128'(idx3(30, 31, 0)));
        tick(); idle();
        chk("full_free", 128'(free_slots), 128'(0));
        for (int w = 0; w < 3; w++) set_disp(w, 32'h3000 + 32'(4 * w));
        tick(); idle();
        chk("full_drop_free", 128'(free_slots), 128'(0));
        chk("full_drop_out0", 128'(rob_out(0)), 128'(exp_disp(32'h1000)));
        chk("full_didx", 128'(dispatch_idx), 128'(idx3(0, 1, 2)));
        for (int w = 0; w < 3; w++) set_cmpl(w, w, 32'(w), 1'b0, 32'h0);
        tick(); idle();
        // Retire with dispatch in the same cycle: no space freed for dispatch
        retire_ack = 3'b111;
        for (int w = 0; w < 3; w++) set_disp(w, 32'h4000 + 32'(4 * w));
        tick(); idle();
        chk("full_ret_free", 128'(free_slots), 128'(3));
        chk("full_ret_out0", 128'(rob_out(0)), 128'(exp_disp(32'h100C)));

        // Walk head and tail to 30 then wrap
        flush();
        for (int c = 0; c < 10; c++) begin
            for (int w = 0; w < 3; w++) set_disp(w, 32'h2000 + 32'(4 * (3 * c + w)));
            tick(); idle();
        end
        for (int c = 0; c < 10; c++) begin
            for (int w = 0; w < 3; w++) set_cmpl(w, 3 * c + w, 32'h0, 1'b0, 32'h0);
            tick(); idle();
        end
        for (int c = 0; c < 10; c++) begin
            retire_ack = 3'b111;
            tick(); idle();
        end
        chk("wrap_empty_free", 128'(free_slots), 128'(32));
        chk("wrap_didx", 128'(dispatch_idx), 128'(idx3(30, 31, 0)));
        chk("wrap_empty_out", 128'(|retire_rob_out), 128'(0));
        set_disp(0, 32'h5000); set_disp(1, 32'h5004); set_disp(2, 32'h5008);
        tick(); idle();
        chk("wrap_out0", 128'(rob_out(0)), 128'(exp_disp(32'h5000)));
        chk("wrap_out2", 128'(rob_out(2)), 128'(exp_disp(32'h5008)));
        set_cmpl(0, 30, 32'h30, 1'b0, 32'h0);
        set_cmpl(1, 31, 32'h31, 1'b0, 32'h0);
        set_cmpl(2, 0, 32'h32, 1'b0, 32'h0);
        tick(); idle();
        p = rob_out(2);
        chk("wrap_cmpl_val", 128'(p[64:33]), 128'(32'h32));
        retire_ack = 3'b111;
        tick(); idle();
        chk("wrap_ret_free", 128'(free_slots), 128'(32));
        chk("wrap_ret_didx", 128'(dispatch_idx), 128'(idx3(1, 2, 3)));
        set_disp(0, 32'h6000);
        tick(); idle();
        chk("wrap_head1", 128'(rob_out(0)), 128'(exp_disp(32'h6000)));

        // Three completions to one index: the highest way wins
        set_cmpl(0, 1, 32'h11, 1'b0, 32'h0);
        set_cmpl(1, 1, 32'h22, 1'b0, 32'h0);
        set_cmpl(2, 1, 32'h33, 1'b1, 32'hCAFE0000);
        tick(); idle();
        p = rob_out(0);
        chk("dup_val", 128'(p[64:33]), 128'(32'h33));
        chk("dup_prec", 128'(p[32]), 128'(1));
        chk("dup_tpc", 128'(p[31:0]), 128'(32'hCAFE0000));

        // Reset with ten entries held; stale completion afterwards is ignored
        flush();
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 3; w++) if (3 * c + w < 10) set_disp(w, 32'h7000 + 32'(4 * (3 * c + w)));
            tick(); idle();
        end
        chk("held10_free", 128'(free_slots), 128'(22));
        reset = 1'b1;
        set_cmpl(0, 4, 32'h44, 1'b0, 32'h0);
        set_disp(0, 32'h8000);
        tick(); idle();
        chk("rst10_free", 128'(free_slots), 128'(32));
        chk("rst10_out", 128'(|retire_rob_out), 128'(0));
        reset = 1'b0;
        set_cmpl(0, 4, 32'h44, 1'b0, 32'h0);
        tick(); idle();
        chk("stale_cmpl_free", 128'(free_slots), 128'(32));
        chk("stale_cmpl_out", 128'(|retire_rob_out), 128'(0));
        chk("stale_cmpl_didx", 128'(dispatch_idx), 128'(idx3(0, 1, 2)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
